avmm_mem_responder: RTL and testbench

- Avalon-MM slave memory: the responder end of the read interface that the controller masters.
- Holds the matrix/vector image of 64-bit words and serves pipelined reads with fixed latency and bounded outstanding reads.
- Accepts byte-enabled writes so a bench or loader can program the contents.
- Drop-in for the controller's avm_* port set; adds write, writedata and byteenable.

---
 rtl/avmm_mem_responder.sv | 114 +++++++++++
 tb/tb_avmm_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_mem_responder.sv
// Avalon-MM slave memory of 64-bit words: byte-enabled writes, pipelined reads.
// Latency: read data returns exactly LATENCY cycles after accept; writes take effect at accept.
// Backpressure: waitrequest high while MAX_PEND reads are outstanding; decoded from registers only.
module avmm_mem_responder #(
    parameter int DEPTH    = 16,
    parameter int LATENCY  = 2,
    parameter int MAX_PEND = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [63:0] writedata,
    input  logic [7:0]  byteenable,
    output logic [63:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest,
    output logic        err_overlap,
    output logic        oor_hit
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MAX_PEND + 1);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] pend_cnt;

    // Read pipeline; the last stage drives the response ports directly so
    // readdata naturally holds the last returned word between strobes.
    logic [LATENCY-1:0] vld_pipe;
    logic [63:0]        dat_pipe [LATENCY];

    logic          accept;
    logic          acc_rd;
    logic          acc_wr;
    logic          oor;
    logic [AW-1:0] idx;
    logic [63:0]   rd_word;

    assign waitrequest = (pend_cnt == PW'(MAX_PEND));
    assign accept      = (read | write) && !waitrequest;
    assign acc_rd      = accept && read;
    // A write that arrives together with a read is dropped.
    assign acc_wr      = accept && write && !read;
    // Full 32-bit compare: upper address bits only matter for range checking.
    assign oor         = (address >= 32'(DEPTH));
    assign idx         = address[AW-1:0];
    assign rd_word     = oor ? 64'd0 : mem[idx];

    assign readdatavalid = vld_pipe[LATENCY-1];
    assign readdata      = dat_pipe[LATENCY-1];

    // Storage array: no reset, contents survive rst; enabled byte lanes only.
    always_ff @(posedge clk) begin
        if (acc_wr && !oor) begin
            for (int b = 0; b < 8; b++) begin
                if (byteenable[b]) begin
                    mem[idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: sample the word at accept, shift toward the response stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                dat_pipe[k] <= '0;
            end
        end else begin
            vld_pipe[0] <= acc_rd;
            if (acc_rd) begin
                dat_pipe[0] <= rd_word;
            end
            for (int k = 1; k < LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) begin
                    dat_pipe[k] <= dat_pipe[k-1];
                end
            end
        end
    end

    // Outstanding-read counter: +1 on read accept, -1 on response strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt <= '0;
        end else begin
            case ({acc_rd, readdatavalid})
                2'b10:   pend_cnt <= pend_cnt + PW'(1);
                2'b01:   pend_cnt <= pend_cnt - PW'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overlap <= 1'b0;
            oor_hit     <= 1'b0;
        end else begin
            if (accept && read && write) begin
                err_overlap <= 1'b1;
            end
            if (accept && oor) begin
                oor_hit <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Bench for avmm_mem_responder: directed steps then random traffic vs a queue-based model.
// Every cycle checks response strobe/data, waitrequest and sticky flags.
// Requests are held while the model predicts waitrequest, as an Avalon master must.
module tb_avmm_mem_responder;

    localparam int DEPTH = 16;
    localparam int LAT   = 2;
    localparam int MAXP  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [63:0] wdat = '0;
    logic [7:0]  be = '0;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    logic        err_overlap;
    logic        oor_hit;

    avmm_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .MAX_PEND(MAXP)) dut (
        .clk           (clk),
        .rst           (rst),
        .address       (addr),
        .read          (rd),
        .write         (wr),
        .writedata     (wdat),
        .byteenable    (be),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .err_overlap   (err_overlap),
        .oor_hit       (oor_hit)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: memory image, in-order response queue with due cycle,
    // last delivered word, sticky flags.
    logic [63:0] mm [DEPTH];
    int          q_due [$];
    logic [63:0] q_dat [$];
    logic [63:0] last_dat = '0;
    bit          m_ovl = 0;
    bit          m_oor = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    // One cycle: compare outputs with the model, apply this cycle's request, advance.
    task automatic tick(output bit acc);
        bit          exp_wait;
        bit          exp_v;
        bit          is_oor;
        logic [63:0] exp_d;
        exp_wait = (q_due.size() == MAXP);
        exp_v    = (q_due.size() > 0) && (q_due[0] == cyc);
        exp_d    = exp_v ? q_dat[0] : last_dat;
        chk("waitrequest", waitrequest, exp_wait);
        chk("readdatavalid", readdatavalid, exp_v);
        chk("readdata", readdata, exp_d);
        chk("err_overlap", err_overlap, m_ovl);
        chk("oor_hit", oor_hit, m_oor);
        if (exp_v) begin
            last_dat = q_dat[0];
            void'(q_due.pop_front());
            void'(q_dat.pop_front());
        end
        acc = (rd || wr) && !exp_wait;
        if (acc) begin
            is_oor = (addr >= DEPTH);
            if (is_oor) m_oor = 1;
            if (rd) begin
                q_due.push_back(cyc + LAT);
                q_dat.push_back(is_oor ? 64'd0 : mm[addr[3:0]]);
                if (wr) m_ovl = 1;
            end else if (!is_oor) begin
                for (int b = 0; b < 8; b++)
                    if (be[b]) mm[addr[3:0]][8*b +: 8] = wdat[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a request and hold it until accepted (bounded).
    task automatic req(input bit r, input bit w, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] b, output int acc_cyc);
        bit acc;
        acc     = 0;
        acc_cyc = -1;
        rd = r; wr = w; addr = a; wdat = d; be = b;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc_cyc = cyc;
            tick(acc);
        end
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout addr=%h got=no-accept exp=accept", a);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        rd = 0; wr = 0;
        repeat (n) tick(a);
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [63:0] d, input logic [7:0] b);
        int c;
        req(0, 1, a, d, b, c);
    endtask

    task automatic rd_word(input logic [31:0] a);
        int c;
        req(1, 0, a, '0, '0, c);
    endtask

    initial begin
        int          c0, c1, c2;
        int          sel;
        logic [31:0] ra;

        // Reset values, checked while rst is high.
        #2;
        chk("rst_readdata", readdata, 64'd0);
        chk("rst_readdatavalid", readdatavalid, 1'b0);
        chk("rst_waitrequest", waitrequest, 1'b0);
        chk("rst_err_overlap", err_overlap, 1'b0);
        chk("rst_oor_hit", oor_hit, 1'b0);
        @(posedge clk);
        #1;
        rst = 0;

        // Preload every word so nothing undefined is ever read back.
        for (int i = 0; i < DEPTH; i++)
            wr_word(i, {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i * 3)}, 8'hFF);

        // Basic read, then byte-enabled partial write.
        wr_word(3, 64'h0102030405060708, 8'hFF);
        rd_word(3);
        idle(LAT + 1);
        wr_word(3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd_word(3);
        idle(LAT + 1);
        chk("byteenable_word", last_dat, 64'h01020304AAAAAAAA);
        wr_word(7, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        rd_word(7);
        idle(LAT + 1);

        // Backpressure with read held high across three addresses.
        wr_word(0, 64'h10, 8'hFF);
        wr_word(1, 64'h11, 8'hFF);
        wr_word(2, 64'h12, 8'hFF);
        idle(1);
        req(1, 0, 0, '0, '0, c0);
        req(1, 0, 1, '0, '0, c1);
        req(1, 0, 2, '0, '0, c2);
        idle(LAT + 2);
        chk("bp_second_accept", 64'(c1 - c0), 64'd1);
        chk("bp_third_accept", 64'(c2 - c0), 64'd3);
        chk("bp_last_word", last_dat, 64'h12);

        // Out-of-range read and write, then reread the whole array.
        rd_word(16);
        wr_word(32'h20, 64'hDEADBEEFDEADBEEF, 8'hFF);
        for (int i = 0; i < DEPTH; i++) rd_word(i);
        idle(LAT + 1);
        chk("oor_sticky", oor_hit, 1'b1);

        // Read and write together: read wins, write dropped.
        wr_word(5, 64'h55, 8'hFF);
        req(1, 1, 5, 64'hFFFFFFFFFFFFFFFF, 8'hFF, c0);
        idle(LAT + 1);
        chk("overlap_data", last_dat, 64'h55);
        rd_word(5);
        idle(LAT + 3);
        chk("overlap_sticky", err_overlap, 1'b1);

        // Reset with a read in flight.
        rd_word(1);
        rd = 0; wr = 0;
        rst = 1;
        #1;
        chk("midrst_readdatavalid", readdatavalid, 1'b0);
        chk("midrst_waitrequest", waitrequest, 1'b0);
        chk("midrst_err_overlap", err_overlap, 1'b0);
        chk("midrst_oor_hit", oor_hit, 1'b0);
        chk("midrst_readdata", readdata, 64'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst = 0;
        q_due.delete();
        q_dat.delete();
        last_dat = '0;
        m_ovl = 0;
        m_oor = 0;
        idle(LAT + 2);
        rd_word(1);
        idle(LAT + 1);
        chk("midrst_retained", last_dat, 64'h11);

        // Random traffic, including idles, overlaps and out-of-range addresses.
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) ra = $urandom;
            else if (sel == 1) ra = 32'($urandom_range(DEPTH, DEPTH + 3));
            else ra = 32'($urandom_range(0, DEPTH - 1));
            case ($urandom_range(0, 3))
                0: idle(1);
                1: rd_word(ra);
                2: wr_word(ra, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
                default: begin
                    if ($urandom_range(0, 7) == 0)
                        req(1, 1, ra, {$urandom, $urandom}, 8'hFF, c0);
                    else
                        rd_word(ra);
                end
            endcase
        end
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
